// File: rtl/frame_draw_sequencer.sv
// Per-frame owner of the VGA write port: rasters background (black / piano ROM), then hands the port to the note drawer.
// Plots appear one cycle after issue (ROM data arrives in that same cycle); no backpressure, one pixel per cycle.
module frame_draw_sequencer #(
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int PIANO_Y      = 92,
    parameter int FRAME_CYCLES = 833333
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic [12:0] o_rom_addr,
    input  logic [23:0] i_rom_colour,
    input  logic        i_note_req,
    input  logic [7:0]  i_note_x,
    input  logic [7:0]  i_note_y,
    input  logic [23:0] i_note_colour,
    input  logic        i_note_done,
    output logic        o_note_ack,
    output logic        o_note_start,
    output logic [7:0]  o_vga_x,
    output logic [7:0]  o_vga_y,
    output logic [23:0] o_vga_colour,
    output logic        o_vga_plot,
    output logic        o_frame_busy,
    output logic        o_frame_done,
    output logic        o_frame_overrun
);
    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_CYCLES - 1);
    localparam logic [7:0]    LAST_X    = 8'(SCREEN_W - 1);
    localparam logic [7:0]    LAST_Y    = 8'(SCREEN_H - 1);
    localparam logic [7:0]    PIANO_ROW = 8'(PIANO_Y);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FLUSH, S_NOTES, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_tick_cnt;
    logic [7:0]    r_sx;
    logic [7:0]    r_sy;
    logic [12:0]   r_rom_addr;
    logic [7:0]    r_vga_x;
    logic [7:0]    r_vga_y;
    logic [23:0]   r_vga_colour;
    logic          r_vga_plot;
    logic          r_src_rom;
    logic          r_note_start;
    logic          r_frame_done;
    logic          r_frame_overrun;

    logic w_tick;
    logic w_note_in_range;

    assign w_tick          = i_enable && (r_tick_cnt == CNT_LAST);
    assign w_note_in_range = ({1'b0, i_note_x} < 9'(SCREEN_W)) && ({1'b0, i_note_y} < 9'(SCREEN_H));

    assign o_note_ack      = i_note_req && (r_state == S_NOTES);
    assign o_rom_addr      = r_rom_addr;
    assign o_note_start    = r_note_start;
    assign o_vga_x         = r_vga_x;
    assign o_vga_y         = r_vga_y;
    // ROM q lands in the stage-2 cycle, so piano pixels take it directly rather than a register.
    assign o_vga_colour    = r_src_rom ? i_rom_colour : r_vga_colour;
    assign o_vga_plot      = r_vga_plot;
    assign o_frame_busy    = (r_state != S_IDLE);
    assign o_frame_done    = r_frame_done;
    assign o_frame_overrun = r_frame_overrun;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_tick_cnt      <= '0;
            r_sx            <= '0;
            r_sy            <= '0;
            r_rom_addr      <= '0;
            r_vga_x         <= '0;
            r_vga_y         <= '0;
            r_vga_colour    <= '0;
            r_vga_plot      <= 1'b0;
            r_src_rom       <= 1'b0;
            r_note_start    <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_overrun <= 1'b0;
        end else begin
            if (i_enable)
                r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + 1'b1;
            r_frame_overrun <= w_tick && (r_state != S_IDLE);
            r_vga_plot      <= 1'b0;
            r_src_rom       <= 1'b0;
            r_note_start    <= 1'b0;
            r_frame_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state    <= S_CLEAR;
                        r_sx       <= '0;
                        r_sy       <= '0;
                        r_rom_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    r_vga_x      <= r_sx;
                    r_vga_y      <= r_sy;
                    r_vga_colour <= '0;
                    r_vga_plot   <= 1'b1;
                    r_src_rom    <= (r_sy >= PIANO_ROW);
                    if (r_sy >= PIANO_ROW)
                        r_rom_addr <= r_rom_addr + 13'd1;
                    if (r_sx == LAST_X) begin
                        r_sx <= '0;
                        if (r_sy == LAST_Y) begin
                            r_state      <= S_FLUSH;
                            r_note_start <= 1'b1;
                        end else begin
                            r_sy <= r_sy + 8'd1;
                        end
                    end else begin
                        r_sx <= r_sx + 8'd1;
                    end
                end
                S_FLUSH: r_state <= S_NOTES;
                S_NOTES: begin
                    r_vga_x      <= i_note_x;
                    r_vga_y      <= i_note_y;
                    r_vga_colour <= i_note_colour;
                    r_vga_plot   <= i_note_req && w_note_in_range;
                    if (i_note_done) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
